// File: rtl/fifo2axis_pkg.sv
// Shared types and width helpers for the fifo2axis store-and-forward bridge.
package fifo2axis_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } out_state_t;

    localparam int DEFAULT_DEPTH   = 16;
    localparam int DEFAULT_PKT_LEN = 4;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // The occupancy count must be able to hold DEPTH itself, not just DEPTH-1.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int beat_width(input int pkt_len);
        return (pkt_len > 1) ? $clog2(pkt_len) : 1;
    endfunction

endpackage

// File: rtl/fifo2axis_mem.sv
// Simple dual-port buffer RAM: one synchronous write port, one combinational read port.
module fifo2axis_mem
    import fifo2axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_W     = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo2axis.sv
// Packet store-and-forward buffer re-emitting collector bursts as an AXI4-Stream master.
// Optional FIFO2AXIS_SOP_EN adds m_axis_tuser marking the first beat of each packet.
module fifo2axis
    import fifo2axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = DEFAULT_PKT_LEN,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  overflow,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
`ifdef FIFO2AXIS_SOP_EN
    ,
    output logic                  m_axis_tuser
`endif
);

    localparam int PTR_W  = ptr_width(DEPTH);
    localparam int CNT_W  = cnt_width(DEPTH);
    localparam int BEAT_W = beat_width(PKT_LEN);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  PKT_LEN_C = CNT_W'(PKT_LEN);
    localparam logic              SOLO_LAST = (PKT_LEN == 1);

    logic [PTR_W-1:0]      wr_ptr, rd_ptr, rd_ptr_next, rd_addr;
    logic [CNT_W-1:0]      count, count_next, pkt_avail;
    logic [BEAT_W-1:0]     in_beat, out_beat, out_beat_d;
    logic                  dropping, drop_now, wr_en, commit;
    logic                  hs, final_beat, more_pkts;
    logic [DATA_WIDTH-1:0] mem_word, rd_word, tdata_d;
    logic                  tvalid_d, tlast_d;
    out_state_t            state, next_state;

    fifo2axis_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_W    (PTR_W)
    ) u_mem (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr),
        .wr_data(din),
        .rd_addr(rd_addr),
        .rd_data(mem_word)
    );

    // Admission is decided once at beat 0 and remembered for the rest of the packet.
    assign drop_now = (in_beat == '0) ? ((DEPTH_C - count) < PKT_LEN_C) : dropping;
    assign wr_en    = din_valid && !drop_now;
    assign commit   = wr_en && (in_beat == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            in_beat  <= '0;
            dropping <= 1'b0;
            wr_ptr   <= '0;
            overflow <= 1'b0;
        end else if (din_valid) begin
            in_beat  <= (in_beat == LAST_BEAT) ? '0 : in_beat + BEAT_W'(1);
            dropping <= drop_now;
            if (drop_now) begin
                overflow <= 1'b1;
            end else begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
        end
    end

    assign hs          = m_axis_tvalid && m_axis_tready;
    assign final_beat  = (out_beat == LAST_BEAT);
    assign more_pkts   = (pkt_avail > CNT_W'(1)) || commit;
    assign rd_ptr_next = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
    assign rd_addr     = hs ? rd_ptr_next : rd_ptr;
    // With one-word packets the word being committed can be the next one to load.
    assign rd_word     = (wr_en && (wr_ptr == rd_addr)) ? din : mem_word;

    always_comb begin
        count_next = count + CNT_W'(wr_en) - CNT_W'(hs);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            full      <= 1'b0;
            pkt_avail <= '0;
            rd_ptr    <= '0;
        end else begin
            count     <= count_next;
            full      <= (count_next == DEPTH_C);
            pkt_avail <= pkt_avail + CNT_W'(commit) - CNT_W'(hs && final_beat);
            if (hs) begin
                rd_ptr <= rd_ptr_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pkt_avail != '0) next_state = SEND;
            SEND:    if (hs && final_beat && !more_pkts) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered stream outputs; holding is the default.
    always_comb begin
        tdata_d    = m_axis_tdata;
        tvalid_d   = m_axis_tvalid;
        tlast_d    = m_axis_tlast;
        out_beat_d = out_beat;
        case (state)
            IDLE: begin
                tvalid_d = 1'b0;
                if (pkt_avail != '0) begin
                    tdata_d    = rd_word;
                    tvalid_d   = 1'b1;
                    tlast_d    = SOLO_LAST;
                    out_beat_d = '0;
                end
            end
            SEND: begin
                if (hs) begin
                    if (!final_beat) begin
                        out_beat_d = out_beat + BEAT_W'(1);
                        tdata_d    = rd_word;
                        tlast_d    = ((out_beat + BEAT_W'(1)) == LAST_BEAT);
                    end else if (more_pkts) begin
                        out_beat_d = '0;
                        tdata_d    = rd_word;
                        tlast_d    = SOLO_LAST;
                    end else begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end
                end
            end
            default: begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            out_beat      <= '0;
        end else begin
            m_axis_tdata  <= tdata_d;
            m_axis_tvalid <= tvalid_d;
            m_axis_tlast  <= tlast_d;
            out_beat      <= out_beat_d;
        end
    end

`ifdef FIFO2AXIS_SOP_EN
    logic tuser_d;

    always_comb begin
        tuser_d = m_axis_tuser;
        if (state == IDLE) begin
            if (pkt_avail != '0) tuser_d = 1'b1;
        end else if (hs) begin
            tuser_d = final_beat && more_pkts;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tuser <= 1'b0;
        end else begin
            m_axis_tuser <= tuser_d;
        end
    end
`endif

endmodule
